// File: rtl/ex_alu_pkg.sv
// Shared types for the EX-stage ALU: opcode encodings, FSM states
// and the default datapath width.
package ex_alu_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_NONE = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_SLTU = 4'd10,
    OP_MUL  = 4'd11
  } aluop_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/ex_alu_if.sv
// ID -> EX -> MEM/WB handshake bundle for the EX-stage ALU.
// master = pipeline side, slave = ALU side.
interface ex_alu_if
  import ex_alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) ();

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imme;
  logic            alusrc;
  logic [3:0]      aluop;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            busy;

  modport master (
    output in_valid, rs1_data, rs2_data,
    output imme, alusrc, aluop, out_ready,
    input  in_ready, out_valid, alu_result,
    input  alu_zero, busy
  );

  modport slave (
    input  in_valid, rs1_data, rs2_data,
    input  imme, alusrc, aluop, out_ready,
    output in_ready, out_valid, alu_result,
    output alu_zero, busy
  );

endinterface

// File: rtl/ex_alu_mul_iter.sv
// Iterative shift-add multiplier, MUL_BITS product bits per cycle.
// start_i latches operands; done_o pulses with product_o on the last step.
module ex_alu_mul_iter
  import ex_alu_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int MUL_BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] product_o
);

  localparam int STEPS = XLEN / MUL_BITS;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic            run_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] acc_d;
  logic            last;

  assign last = (cnt_q == CW'(STEPS - 1));

  // Only the low XLEN product bits are kept, so the accumulator wraps.
  always_comb begin
    acc_d = acc_q;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (mplier_q[j]) begin
        acc_d = acc_d + (mcand_q << j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      run_q    <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << MUL_BITS;
      mplier_q <= mplier_q >> MUL_BITS;
      cnt_q    <= cnt_q + 1'b1;
      if (last) begin
        run_q <= 1'b0;
      end
    end
  end

  assign done_o    = run_q && last;
  assign product_o = acc_d;

endmodule

// File: rtl/ex_alu_unit.sv
// EX-stage ALU with valid/ready handshake and registered result.
// Define EX_ALU_MUL_EN to build the iterative multiplier (MUL opcode).
module ex_alu_unit
  import ex_alu_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int SHAMT_W  = $clog2(XLEN),
  parameter int MUL_BITS = 1
) (
  input  logic    clk,
  input  logic    reset,
  ex_alu_if.slave io
);

  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] alu_y;
  logic [SHAMT_W-1:0] shamt;

  state_e          state_q;
  state_e          state_d;
  logic [XLEN-1:0] res_q;
  logic [XLEN-1:0] res_d;
  logic            zero_q;
  logic            zero_d;
  logic            vld_q;
  logic            vld_d;
  logic            fire_in;
  logic            fire_out;

  assign op1   = io.rs1_data;
  assign op2   = io.alusrc ? io.imme : io.rs2_data;
  assign shamt = op2[SHAMT_W-1:0];

  assign io.in_ready = (state_q == IDLE)
                    && (!vld_q || io.out_ready);

  assign fire_in  = io.in_valid && io.in_ready;
  assign fire_out = vld_q && io.out_ready;

  always_comb begin
    alu_y = '0;
    case (io.aluop)
      OP_ADD:  alu_y = op1 + op2;
      OP_SUB:  alu_y = op1 - op2;
      OP_AND:  alu_y = op1 & op2;
      OP_OR:   alu_y = op1 | op2;
      OP_XOR:  alu_y = op1 ^ op2;
      OP_SLT:  alu_y = XLEN'($signed(op1) < $signed(op2));
      OP_SLTU: alu_y = XLEN'(op1 < op2);
      OP_SLL:  alu_y = op1 << shamt;
      OP_SRL:  alu_y = op1 >> shamt;
      OP_SRA:  alu_y = $unsigned($signed(op1) >>> shamt);
      OP_NONE: alu_y = '0;
      default: alu_y = '0;
    endcase
  end

`ifdef EX_ALU_MUL_EN
  logic            mul_start;
  logic            mul_done;
  logic [XLEN-1:0] mul_prod;

  assign mul_start = fire_in && (io.aluop == OP_MUL);

  ex_alu_mul_iter #(
    .XLEN     (XLEN),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start_i   (mul_start),
    .a_i       (op1),
    .b_i       (op2),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  assign io.busy = (state_q == MUL);
`else
  logic unused_cfg;
  assign unused_cfg = ^MUL_BITS;
  assign io.busy    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    vld_d   = vld_q;
    if (fire_out) begin
      vld_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (fire_in) begin
`ifdef EX_ALU_MUL_EN
          if (mul_start) begin
            state_d = MUL;
            vld_d   = 1'b0;
          end else begin
            res_d = alu_y;
            vld_d = 1'b1;
          end
`else
          res_d = alu_y;
          vld_d = 1'b1;
`endif
        end
      end
      MUL: begin
`ifdef EX_ALU_MUL_EN
        if (mul_done) begin
          res_d   = mul_prod;
          vld_d   = 1'b1;
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign zero_d = (res_d == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      zero_q  <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      vld_q   <= vld_d;
    end
  end

  assign io.out_valid  = vld_q;
  assign io.alu_result = res_q;
  assign io.alu_zero   = zero_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Bench for ex_alu_unit: cycle model + per-cycle compare + directed vectors.
module tb_ex_alu_unit;
  import ex_alu_pkg::*;

`ifdef EX_ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_alu_if #(.XLEN(32)) bus ();

  ex_alu_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  logic [31:0] outq[$];

  logic        m_vld, m_busy;
  logic [31:0] m_res, m_mul;
  int          m_left;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(int op, logic [31:0] a,
                                          logic [31:0] b);
    logic [4:0] s;
    s = b[4:0];
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      7:  return a << s;
      8:  return a >> s;
      9:  return $unsigned($signed(a) >>> s);
      10: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Reference model: what the unit must show after each clock edge.
  always @(posedge clk) begin : mdl
    logic        n_vld, n_busy, rdy, take;
    logic [31:0] n_res, n_mul, o2;
    int          n_left;
    n_vld = m_vld; n_busy = m_busy; n_res = m_res;
    n_mul = m_mul; n_left = m_left;
    if (reset) begin
      n_vld = 0; n_busy = 0; n_res = 0; n_left = 0;
    end else begin
      rdy  = !m_busy && (!m_vld || bus.out_ready);
      take = bus.in_valid && rdy;
      o2   = bus.alusrc ? bus.imme : bus.rs2_data;
      if (m_vld && bus.out_ready) n_vld = 0;
      if (m_busy) begin
        n_left = m_left - 1;
        if (n_left == 0) begin
          n_busy = 0; n_vld = 1; n_res = m_mul;
        end
      end else if (take) begin
        if (MUL_ON && bus.aluop == 4'd11) begin
          n_busy = 1; n_left = 32; n_mul = bus.rs1_data * o2;
        end else begin
          n_res = ref_alu(int'(bus.aluop), bus.rs1_data, o2);
          n_vld = 1;
        end
      end
    end
    m_vld <= n_vld; m_busy <= n_busy; m_res <= n_res;
    m_mul <= n_mul; m_left <= n_left;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(bus.in_ready),
          32'(!m_busy && (!m_vld || bus.out_ready)));
      chk("out_valid", 32'(bus.out_valid), 32'(m_vld));
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("alu_result", bus.alu_result, m_res);
      chk("alu_zero", 32'(bus.alu_zero), 32'(m_res == 0));
      if (bus.out_valid && bus.out_ready) outq.push_back(bus.alu_result);
    end
  end

  task automatic issue(logic [3:0] op, logic [31:0] a, logic [31:0] r2,
                       logic [31:0] im, logic src);
    int n;
    logic rdy;
    bus.aluop = op; bus.rs1_data = a; bus.rs2_data = r2;
    bus.imme = im; bus.alusrc = src; bus.in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 200) begin
        n_chk++; n_err++;
        $display("FAIL issue timeout op=%0d got no accept expected accept", op);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic lit(string nm, logic [31:0] exp);
    @(negedge clk);
    chk({nm, " valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, " result"}, bus.alu_result, exp);
    chk({nm, " zero"}, 32'(bus.alu_zero), 32'(exp == 0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.in_valid = 0; bus.out_ready = 1; bus.aluop = 0;
    bus.rs1_data = 0; bus.rs2_data = 0; bus.imme = 0; bus.alusrc = 0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst valid", 32'(bus.out_valid), 32'd0);
    chk("rst result", bus.alu_result, 32'd0);
    chk("rst zero", 32'(bus.alu_zero), 32'd1);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    issue(4'd0, 32'd5, 32'd100, 32'd7, 1'b1);          lit("add", 32'd12);
    issue(4'd1, 32'd9, 32'd9, 32'd3, 1'b0);            lit("sub", 32'd0);
    issue(4'd5, 32'hFFFFFFFF, 0, 32'd1, 1'b1);         lit("slt", 32'd1);
    issue(4'd10, 32'hFFFFFFFF, 0, 32'd1, 1'b1);        lit("sltu", 32'd0);
    issue(4'd9, 32'h80000000, 0, 32'd4, 1'b1);         lit("sra", 32'hF8000000);
    issue(4'd8, 32'h80000000, 0, 32'd4, 1'b1);         lit("srl", 32'h08000000);
    issue(4'd7, 32'd1, 32'd33, 0, 1'b0);               lit("sll33", 32'd2);
    issue(4'd2, 32'hF0F0, 32'h0FF0, 0, 1'b0);          lit("and", 32'h00F0);
    issue(4'd3, 32'hF0F0, 32'h0FF0, 0, 1'b0);          lit("or", 32'hFFF0);
    issue(4'd4, 32'hF0F0, 32'h0FF0, 0, 1'b0);          lit("xor", 32'hFF00);
    issue(4'd6, 32'd7, 32'd8, 0, 1'b0);                lit("none", 32'd0);
    issue(4'd15, 32'd7, 32'd8, 0, 1'b0);               lit("undef", 32'd0);
    issue(4'd0, 32'hFFFFFFFF, 32'd1, 0, 1'b0);         lit("wrap", 32'd0);

    // back-pressure: three back-to-back ADDs while out_ready low
    outq.delete();
    bus.out_ready = 1'b0;
    fork
      begin
        issue(4'd0, 32'd1, 32'd2, 0, 1'b0);
        issue(4'd0, 32'd10, 32'd20, 0, 1'b0);
        issue(4'd0, 32'd100, 32'd200, 0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp held", bus.alu_result, 32'd3);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("bp count", outq.size(), 32'd3);
    if (outq.size() == 3) begin
      chk("bp first", outq[0], 32'd3);
      chk("bp second", outq[1], 32'd30);
      chk("bp third", outq[2], 32'd300);
    end

`ifdef EX_ALU_MUL_EN
    begin
      int n;
      issue(4'd11, 32'h0000FFFF, 32'h00010001, 0, 1'b0);
      n = 0;
      while (n < 40 && !bus.out_valid) begin
        chk("mul busy", 32'(bus.busy), 32'd1);
        chk("mul in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        n++;
      end
      chk("mul latency", n, 32'd32);
      chk("mul result", bus.alu_result, 32'hFFFFFFFF);
      @(posedge clk); #1;
      issue(4'd11, 32'd6, 32'd7, 0, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort valid", 32'(bus.out_valid), 32'd0);
      chk("abort busy", 32'(bus.busy), 32'd0);
      chk("abort result", bus.alu_result, 32'd0);
      chk("abort in_ready", 32'(bus.in_ready), 32'd1);
      reset = 1'b0;
      @(posedge clk); #1;
    end
`else
    issue(4'd11, 32'd3, 32'd4, 0, 1'b0);               lit("mul off", 32'd0);
`endif

    issue(4'd0, 32'd40, 32'd2, 0, 1'b0);               lit("post", 32'd42);
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
